// File: rtl/adc_sampler.sv
// adc_sampler: paces conversions of a 16-bit-frame serial ADC at a fixed
// sample rate and hands each 12-bit result to the sample FIFO as a
// one-cycle enqueue strobe. Samples arriving while the FIFO is full are
// dropped and recorded in a sticky overrun flag and a saturating counter.
module adc_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_sdata,
  input  logic        full,
  output logic [11:0] data_out,
  output logic        enqueue,
  output logic        overrun,
  output logic [7:0]  drop_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]       BIT_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  // Drop counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic             phase_q, phase_d;    // 1: SCLK high phase, 0: low phase
  logic [11:0]      shift_q, shift_d;    // leading frame bits fall off the top
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic [11:0]      data_q, data_d;
  logic             enq_q, enq_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       drop_q, drop_d;
  logic             tick_s;

  // Next-state logic: rate counter, conversion sequencer and the output values
  // for the state being entered, so every output is a plain flop.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shift_d = shift_q;
    data_d  = data_q;
    enq_d   = 1'b0;
    ovr_d   = ovr_q;
    drop_d  = drop_q;
    sync1_d = adc_sdata;
    sync2_d = sync1_q;

    // Sample-rate counter; parked at zero while disabled.
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    tick_s = enable && (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        // Ticks seen in any other state are simply lost.
        if (tick_s) begin
          state_d = ST_SETUP;
          div_d   = {DIV_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d   = {DIV_W{1'b0}};
          bit_d   = 4'd0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = {DIV_W{1'b0}};
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // End of the high phase: capture the bit, start the next one.
            shift_d = {shift_q[10:0], sync2_q};
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_HOLD;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_EMIT;
          div_d   = {DIV_W{1'b0}};
          // Decide accept/drop now so the strobe is registered and lands in
          // the EMIT cycle. Only this block writes the FIFO, so full cannot
          // newly assert between this look and the strobe.
          if (!full) begin
            data_d = shift_q;
            enq_d  = 1'b1;
          end else begin
            ovr_d  = 1'b1;
            drop_d = sat_inc8(drop_q);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_EMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = {DIV_W{1'b0}};
        bit_d   = 4'd0;
        phase_d = 1'b0;
      end
    endcase

    // Pin levels follow the state being entered.
    if ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) begin
      cs_n_d = 1'b0;
    end else begin
      cs_n_d = 1'b1;
    end
    if ((state_d == ST_SHIFT) && !phase_d) begin
      sclk_d = 1'b0;
    end else begin
      sclk_d = 1'b1;
    end
  end

  // All state and output registers; reset returns the ADC pins to idle at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      div_q   <= {DIV_W{1'b0}};
      bit_q   <= 4'd0;
      phase_q <= 1'b0;
      shift_q <= 12'd0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      data_q  <= 12'd0;
      enq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      enq_q   <= enq_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign data_out   = data_q;
  assign enqueue    = enq_q;
  assign overrun    = ovr_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: directed bench for adc_sampler with a serial ADC model, a
// timing-level reference model checked every cycle, and literal expectations.
module tb_adc_sampler;

  localparam int CD = 4;
  localparam int SP = 160;
  localparam int LAT = 1 + 34 * CD;   // tick to enqueue

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_sdata = 1'b0;
  logic        full = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        enqueue;
  logic        overrun;
  logic [11:0] data_out;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_bad = 0;

  adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_sdata  (adc_sdata),
    .full       (full),
    .data_out   (data_out),
    .enqueue    (enqueue),
    .overrun    (overrun),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  // Frame the ADC returns for the n-th conversion since time zero.
  function automatic logic [15:0] frame_for(input int n);
    logic [15:0] f;
    if (n == 0) f = 16'h0ABC;
    else if (n <= 8) f = 16'(n - 1);
    else f = 16'((n * 311) ^ 16'hA5A5);
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC model: new frame on chip-select fall, next bit after each SCLK fall.
  int          a_conv = 0;
  int          a_bit = 15;
  logic [15:0] a_frame = 16'h0000;
  logic        a_prev_cs = 1'b1;
  logic        a_prev_sclk = 1'b1;
  always @(negedge clock) begin
    if (adc_cs_n == 1'b0 && a_prev_cs == 1'b1) begin
      a_frame = frame_for(a_conv);
      a_conv++;
      a_bit = 15;
    end
    if (adc_cs_n == 1'b0 && adc_sclk == 1'b0 && a_prev_sclk == 1'b1 && a_bit >= 0) begin
      adc_sdata = a_frame[a_bit];
      a_bit--;
    end
    a_prev_cs = adc_cs_n;
    a_prev_sclk = adc_sclk;
  end

  // Reference model: expected outputs as a function of time since the tick.
  int          cyc = 0;
  int          m_cnt = 0;
  int          m_t = -100000;
  int          m_conv = 0;
  int          m_idx = 0;
  bit          m_active = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_emit_now = 1'b0;
  logic [15:0] m_fr;
  logic        e_cs = 1'b1, e_sclk = 1'b1, e_enq = 1'b0, e_ovr = 1'b0;
  logic [11:0] e_data = 12'd0;
  logic [7:0]  e_drop = 8'd0;
  always @(posedge clock) begin
    int prev;
    int rel;
    bit idle;
    prev = cyc;
    cyc = cyc + 1;
    m_emit_now = 1'b0;
    if (reset) begin
      m_cnt = 0; m_active = 1'b0;
      e_cs = 1'b1; e_sclk = 1'b1; e_enq = 1'b0; e_data = 12'd0; e_ovr = 1'b0; e_drop = 8'd0;
    end else begin
      idle = !m_active || (prev >= m_t + LAT + 1);
      if (enable && m_cnt == SP - 1 && idle) begin
        m_t = prev; m_active = 1'b1; m_idx = m_conv; m_conv++;
      end
      m_cnt = enable ? ((m_cnt == SP - 1) ? 0 : m_cnt + 1) : 0;
      rel = cyc - m_t;
      e_cs = !(m_active && rel >= 1 && rel <= 33 * CD);
      e_sclk = !(m_active && rel >= 1 + CD && rel <= 33 * CD && (((rel - 1 - CD) / CD) % 2) == 0);
      e_enq = 1'b0;
      if (m_active && rel == LAT) begin
        m_emit_now = 1'b1;
        if (!full) begin
          m_fr = frame_for(m_idx);
          e_enq = 1'b1;
          e_data = m_fr[11:0];
        end else begin
          e_ovr = 1'b1;
          if (e_drop != 8'hFF) e_drop = e_drop + 8'd1;
        end
      end
    end
    m_valid = 1'b1;
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("cyc_cs_n", 32'(adc_cs_n), 32'(e_cs));
      chk("cyc_sclk", 32'(adc_sclk), 32'(e_sclk));
      chk("cyc_enqueue", 32'(enqueue), 32'(e_enq));
      chk("cyc_data_out", 32'(data_out), 32'(e_data));
      chk("cyc_overrun", 32'(overrun), 32'(e_ovr));
      chk("cyc_drop_count", 32'(drop_count), 32'(e_drop));
    end
  end

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  // Run until the next enqueue, recording its timing and the SCLK pulses.
  task automatic watch_one(output bit seen, output int enq_c, output int cs_c,
                           output int pulses, output logic [11:0] d);
    logic pcs, psc;
    seen = 1'b0; enq_c = 0; cs_c = 0; pulses = 0; d = 12'd0;
    pcs = adc_cs_n; psc = adc_sclk;
    for (int k = 0; k < 2 * SP + 50 && !seen; k++) begin
      step();
      if (pcs && !adc_cs_n) begin cs_c = cyc; pulses = 0; end
      if (!adc_cs_n && psc && !adc_sclk) pulses++;
      if (enqueue) begin seen = 1'b1; enq_c = cyc; d = data_out; end
      pcs = adc_cs_n; psc = adc_sclk;
    end
    chk("enqueue_seen", 32'(seen), 32'd1);
  endtask

  // Run until the model's next EMIT cycle, counting DUT strobes on the way.
  task automatic wait_emit(inout int enq_seen);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2 * SP + 50 && !got; k++) begin
      step();
      if (enqueue) enq_seen++;
      got = m_emit_now;
    end
    chk("emit_reached", 32'(got), 32'd1);
  endtask

  initial begin
    bit          seen;
    int          enq_c, cs_c, pulses, prev_enq, en_cyc, n_enq, n_fall;
    logic [11:0] d;
    logic        pcs;

    // Reset state.
    repeat (3) step();
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_enqueue", 32'(enqueue), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    step();

    // First conversion: frame 0x0ABC.
    enable = 1'b1;
    en_cyc = cyc;
    watch_one(seen, enq_c, cs_c, pulses, d);
    chk("first_latency", 32'(enq_c - en_cyc), 32'(SP + 136));
    chk("cs_to_enqueue", 32'(enq_c - cs_c), 32'd136);
    chk("sclk_pulses", 32'(pulses), 32'd16);
    chk("first_data", 32'(d), 32'h0ABC);
    prev_enq = enq_c;

    // Eight back-to-back conversions returning 0..7.
    for (int i = 0; i < 8; i++) begin
      watch_one(seen, enq_c, cs_c, pulses, d);
      chk("run_spacing", 32'(enq_c - prev_enq), 32'(SP));
      chk("run_data", 32'(d), 32'(i));
      chk("run_pulses", 32'(pulses), 32'd16);
      prev_enq = enq_c;
    end

    // FIFO full across three EMITs.
    step();
    full = 1'b1;
    n_enq = 0;
    for (int i = 0; i < 3; i++) wait_emit(n_enq);
    step();
    chk("full_no_enqueue", 32'(n_enq), 32'd0);
    chk("full_drop_count", 32'(drop_count), 32'd3);
    chk("full_overrun", 32'(overrun), 32'd1);
    chk("full_data_kept", 32'(data_out), 32'h007);
    full = 1'b0;
    watch_one(seen, enq_c, cs_c, pulses, d);
    chk("resume_data", 32'(d), 32'hB31);
    chk("resume_overrun", 32'(overrun), 32'd1);
    chk("resume_drop_count", 32'(drop_count), 32'd3);

    // Saturation: 300 more dropped samples.
    step();
    full = 1'b1;
    n_enq = 0;
    for (int i = 0; i < 300; i++) wait_emit(n_enq);
    step();
    chk("sat_no_enqueue", 32'(n_enq), 32'd0);
    chk("sat_drop_count", 32'(drop_count), 32'd255);
    chk("sat_data_kept", 32'(data_out), 32'hB31);
    full = 1'b0;

    // Disable mid-SHIFT: the conversion finishes, then the ADC stays quiet.
    for (int k = 0; k < 2 * SP && adc_cs_n; k++) step();
    repeat (20) step();
    enable = 1'b0;
    n_enq = 0; n_fall = 0; pcs = adc_cs_n;
    repeat (3 * SP + 200) begin
      step();
      if (enqueue) n_enq++;
      if (pcs && !adc_cs_n) n_fall++;
      pcs = adc_cs_n;
    end
    chk("disable_enqueues", 32'(n_enq), 32'd1);
    chk("disable_cs_falls", 32'(n_fall), 32'd0);

    // Reset mid-SHIFT: pins idle at once, next sample needs a fresh tick.
    enable = 1'b1;
    for (int k = 0; k < 2 * SP && adc_cs_n; k++) step();
    repeat (30) step();
    reset = 1'b1;
    #1;
    chk("async_cs_n", 32'(adc_cs_n), 32'd1);
    chk("async_sclk", 32'(adc_sclk), 32'd1);
    chk("async_overrun", 32'(overrun), 32'd0);
    step();
    reset = 1'b0;
    en_cyc = cyc;
    watch_one(seen, enq_c, cs_c, pulses, d);
    chk("post_reset_latency", 32'(enq_c - en_cyc), 32'(SP + 136));
    chk("post_reset_drop_count", 32'(drop_count), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
